// File: rtl/boot_rom_copier.sv
// Boot ROM shadow copier: reads N words from the boot ROM and writes them
// through a req/gnt memory port, then pulses done_o.
module boot_rom_copier #(
   parameter int ROM_ADDR_WIDTH = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start_i,
   input  logic [ROM_ADDR_WIDTH-2:0]   num_words_i,
   input  logic [MEM_ADDR_WIDTH-1:0]   dst_addr_i,
   output logic                        rom_en_o,
   output logic [ROM_ADDR_WIDTH-1:0]   rom_addr_o,
   input  logic [DATA_WIDTH-1:0]       rom_rdata_i,
   output logic                        mem_req_o,
   output logic [MEM_ADDR_WIDTH-1:0]   mem_addr_o,
   output logic                        mem_we_o,
   output logic [DATA_WIDTH/8-1:0]     mem_be_o,
   output logic [DATA_WIDTH-1:0]       mem_wdata_o,
   input  logic                        mem_gnt_i,
   output logic                        busy_o,
   output logic                        done_o
);

   localparam int WW = ROM_ADDR_WIDTH - 2;
   localparam int NW = ROM_ADDR_WIDTH - 1;
   localparam logic [NW-1:0] DEPTH = {1'b1, {WW{1'b0}}};
   localparam logic [MEM_ADDR_WIDTH-1:0] BPW = MEM_ADDR_WIDTH'(DATA_WIDTH / 8);

   typedef enum logic [2:0] {IDLE, RD, LAT, WR, DONE} state_t;

   state_t                    state_q, state_d;
   logic [WW-1:0]             cnt_q;
   logic [NW-1:0]             rem_q;
   logic [MEM_ADDR_WIDTH-1:0] dptr_q;
   logic [DATA_WIDTH-1:0]     wbuf_q;
   logic [NW-1:0]             rem_start;

   // Clamping to ROM depth keeps the ROM address from ever wrapping.
   assign rem_start = (num_words_i > DEPTH) ? DEPTH : num_words_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dptr_q  <= '0;
         wbuf_q  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (start_i) begin
               cnt_q  <= '0;
               rem_q  <= rem_start;
               dptr_q <= dst_addr_i;
            end
            LAT:  wbuf_q <= rom_rdata_i;
            WR:   if (mem_gnt_i) begin
               cnt_q  <= cnt_q + WW'(1);
               rem_q  <= rem_q - NW'(1);
               dptr_q <= dptr_q + BPW;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      rom_en_o    = 1'b0;
      rom_addr_o  = '0;
      mem_req_o   = 1'b0;
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      case (state_q)
         IDLE: if (start_i) state_d = (rem_start == '0) ? DONE : RD;
         RD: begin
            rom_en_o   = 1'b1;
            rom_addr_o = {cnt_q, 2'b00};
            busy_o     = 1'b1;
            state_d    = LAT;
         end
         LAT: begin
            busy_o  = 1'b1;
            state_d = WR;
         end
         WR: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_be_o    = '1;
            mem_addr_o  = dptr_q;
            mem_wdata_o = wbuf_q;
            busy_o      = 1'b1;
            if (mem_gnt_i) state_d = (rem_q == NW'(1)) ? DONE : RD;
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/boot_rom_copier.md
Name: boot_rom_copier

Overview:
- Initiator for the boot ROM's synchronous read port: copies a block of words from the boot ROM into on-chip RAM through a req/gnt memory port, then signals completion.
- Sits between the boot ROM wrapper and the TCDM/L2 interconnect.
- Used at power-up to shadow boot code into RAM before releasing the core fetch.

Parameters:
- ROM_ADDR_WIDTH, 12, byte-address width of the boot ROM; depth = 2^(ROM_ADDR_WIDTH-2) words.
- DATA_WIDTH, 32, ROM and memory word width.
- MEM_ADDR_WIDTH, 32, byte-address width of the destination memory port.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start_i  input  1  one-cycle request to begin a copy
- num_words_i  input  ROM_ADDR_WIDTH-1  words to copy, sampled with start_i
- dst_addr_i  input  MEM_ADDR_WIDTH  destination byte base address, sampled with start_i
- rom_en_o  output  1  ROM read enable
- rom_addr_o  output  ROM_ADDR_WIDTH  ROM byte address; bits [1:0] always 0
- rom_rdata_i  input  DATA_WIDTH  ROM read data, valid the cycle after rom_en_o
- mem_req_o  output  1  destination write request
- mem_addr_o  output  MEM_ADDR_WIDTH  destination byte address
- mem_we_o  output  1  write enable; 1 whenever mem_req_o=1
- mem_be_o  output  DATA_WIDTH/8  byte enables; all ones
- mem_wdata_o  output  DATA_WIDTH  write data
- mem_gnt_i  input  1  grant; the write completes in the cycle where req=1 and gnt=1
- busy_o  output  1  high from the cycle after an accepted start until DONE
- done_o  output  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0, FSM=IDLE, counters and data register 0. Reset mid-copy aborts immediately; no done_o pulse is issued.
- Internal state: word counter cnt; remaining count rem, clamped to min(num_words_i, 2^(ROM_ADDR_WIDTH-2)) at start; destination pointer dptr; data register wbuf.
- IDLE:
  - start_i=1 and rem'=0 -> DONE; no ROM or memory access.
  - start_i=1 otherwise -> RD, with cnt=0 and dptr=dst_addr_i.
  - start_i is ignored in every state except IDLE.
- RD (1 cycle): rom_en_o=1, rom_addr_o={cnt,2'b00}. Next state LAT.
- LAT (1 cycle): rom_en_o=0; wbuf<=rom_rdata_i. Next state WR.
- WR:
  - mem_req_o=1, mem_addr_o=dptr, mem_wdata_o=wbuf.
  - req, addr and wdata are held stable until gnt; req is never retracted.
  - On gnt: cnt+=1, dptr+=DATA_WIDTH/8 (wraps modulo 2^MEM_ADDR_WIDTH), rem-=1.
  - Next state: RD if rem≠0, else DONE.
  - gnt seen while req=0 is ignored.
- DONE (1 cycle): done_o=1, busy_o=0. Next state IDLE.
  - A start_i arriving in DONE is ignored.
  - A start_i arriving the following cycle (in IDLE) is accepted.
- busy_o=1 in RD, LAT and WR.
- ROM address wraps within ROM depth; this cannot occur because rem is clamped.
- Throughput: 3 cycles per word with gnt tied high.
- Latency with gnt=1: start_i to done_o = 3N+1 cycles for N>0; 1 cycle for N=0.
- rom_en_o is asserted for exactly N cycles per copy. mem_req_o/gnt handshakes complete exactly N times.

Test Plan:
- Basic copy:
  - Stimulus: ROM model holds word k = 0xB000_0000+k; start_i with num_words_i=4, dst_addr_i=0x1C00_0000; gnt tied 1.
  - Required: writes of 0xB0000000..0xB0000003 to 0x1C000000, 0x1C000004, 0x1C000008, 0x1C00000C in that order; done_o exactly 13 cycles after start_i.
- Backpressure:
  - Stimulus: gnt low for 5 cycles on each request; num_words_i=2.
  - Required: mem_addr_o and mem_wdata_o stable while req=1 and gnt=0; exactly 2 writes; no duplicate or dropped words.
- Zero length:
  - Stimulus: num_words_i=0.
  - Required: done_o 1 cycle after start_i; rom_en_o and mem_req_o never asserted.
- Clamp and destination wrap:
  - Stimulus: ROM_ADDR_WIDTH=4 (4 words), num_words_i=7, dst_addr_i=0xFFFF_FFF8.
  - Required: exactly 4 writes to 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; last rom_addr_o=0xC.
- Reset and start-while-busy:
  - Stimulus: start_i pulsed again during WR of copy 1; then rst asserted during the second word's WR.
  - Required: the extra start is ignored; after rst, all outputs are 0 the next cycle, no done_o pulse, and a fresh start performs a full copy from ROM word 0.
